// File: rtl/axi_interconnect.sv
`default_nettype none
// ============================================================================
// Module      : axi_interconnect
// Description : 2-master x 2-slave AXI read-path (AR + R) interconnect with
//               inclusive address decode, per-slave IDLE/ADDR/DATA FSMs and a
//               per-master DECERR responder for unmapped addresses.
//               Optional macro AXI_IC_RR_ARB_EN selects round-robin arbitration
//               on same-slave contention; otherwise master 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_interconnect (
    input  logic        G_clk,
    input  logic        G_reset,
    // master 0
    input  logic [31:0] M0_ARADDR,
    input  logic [3:0]  M0_ARLEN,
    input  logic [2:0]  M0_ARSIZE,
    input  logic [1:0]  M0_ARBURST,
    input  logic        M0_ARVALID,
    input  logic        M0_RREADY,
    output logic        ARREADY_M0,
    output logic        RVALID_M0,
    output logic        RLAST_M0,
    output logic [1:0]  RRESP_M0,
    output logic [31:0] RDATA_M0,
    // master 1
    input  logic [31:0] M1_ARADDR,
    input  logic [3:0]  M1_ARLEN,
    input  logic [2:0]  M1_ARSIZE,
    input  logic [1:0]  M1_ARBURST,
    input  logic        M1_ARVALID,
    input  logic        M1_RREADY,
    output logic        ARREADY_M1,
    output logic        RVALID_M1,
    output logic        RLAST_M1,
    output logic [1:0]  RRESP_M1,
    output logic [31:0] RDATA_M1,
    // slave 0
    input  logic        S0_ARREADY,
    input  logic        S0_RVALID,
    input  logic        S0_RLAST,
    input  logic [1:0]  S0_RRESP,
    input  logic [31:0] S0_RDATA,
    output logic [31:0] ARADDR_S0,
    output logic [3:0]  ARLEN_S0,
    output logic [2:0]  ARSIZE_S0,
    output logic [1:0]  ARBURST_S0,
    output logic        ARVALID_S0,
    output logic        RREADY_S0,
    // slave 1
    input  logic        S1_ARREADY,
    input  logic        S1_RVALID,
    input  logic        S1_RLAST,
    input  logic [1:0]  S1_RRESP,
    input  logic [31:0] S1_RDATA,
    output logic [31:0] ARADDR_S1,
    output logic [3:0]  ARLEN_S1,
    output logic [2:0]  ARSIZE_S1,
    output logic [1:0]  ARBURST_S1,
    output logic        ARVALID_S1,
    output logic        RREADY_S1,
    // address map (inclusive bounds)
    input  logic [31:0] slave0_addr1,
    input  logic [31:0] slave0_addr2,
    input  logic [31:0] slave1_addr1,
    input  logic [31:0] slave1_addr2
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ADDR      = 2'd1;
    localparam logic [1:0] S_DATA      = 2'd2;
    localparam logic [1:0] D_IDLE      = 2'd0;
    localparam logic [1:0] D_ACK       = 2'd1;
    localparam logic [1:0] D_RESP      = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // per-master views of the ports
    logic [1:0][31:0] m_araddr;
    logic [1:0][3:0]  m_arlen;
    logic [1:0][2:0]  m_arsize;
    logic [1:0][1:0]  m_arburst;
    logic [1:0]       m_arvalid;
    logic [1:0]       m_rready;
    logic [1:0]       m_arready;
    logic [1:0]       m_rvalid;
    logic [1:0]       m_rlast;
    logic [1:0][1:0]  m_rresp;
    logic [1:0][31:0] m_rdata;

    // per-slave views of the ports
    logic [1:0]       s_arready;
    logic [1:0]       s_rvalid;
    logic [1:0]       s_rlast;
    logic [1:0][1:0]  s_rresp;
    logic [1:0][31:0] s_rdata;
    logic [1:0][31:0] s_araddr;
    logic [1:0][3:0]  s_arlen;
    logic [1:0][2:0]  s_arsize;
    logic [1:0][1:0]  s_arburst;
    logic [1:0]       s_arvalid;
    logic [1:0]       s_rready;

    // decode / request matrix
    logic [1:0]       in_s0;
    logic [1:0]       in_s1;
    logic [1:0]       unmapped;
    logic [1:0]       busy;
    logic [1:0][1:0]  req;          // req[slave][master]

    // FSM state
    logic [1:0][1:0]  slv_state;
    logic [1:0][1:0]  slv_state_nxt;
    logic [1:0]       owner;
    logic [1:0]       owner_nxt;
    logic [1:0][1:0]  dec_state;
    logic [1:0][1:0]  dec_state_nxt;
`ifdef AXI_IC_RR_ARB_EN
    logic [1:0]       last_grant;
    logic [1:0]       last_grant_nxt;
`endif

    assign m_araddr  = {M1_ARADDR,  M0_ARADDR};
    assign m_arlen   = {M1_ARLEN,   M0_ARLEN};
    assign m_arsize  = {M1_ARSIZE,  M0_ARSIZE};
    assign m_arburst = {M1_ARBURST, M0_ARBURST};
    assign m_arvalid = {M1_ARVALID, M0_ARVALID};
    assign m_rready  = {M1_RREADY,  M0_RREADY};
    assign s_arready = {S1_ARREADY, S0_ARREADY};
    assign s_rvalid  = {S1_RVALID,  S0_RVALID};
    assign s_rlast   = {S1_RLAST,   S0_RLAST};
    assign s_rresp   = {S1_RRESP,   S0_RRESP};
    assign s_rdata   = {S1_RDATA,   S0_RDATA};

    // Address decode (slave 0 wins overlaps) and per-master outstanding flag
    always_comb begin
        in_s0    = '0;
        in_s1    = '0;
        unmapped = '0;
        busy     = '0;
        req      = '0;
        for (int m = 0; m < 2; m++) begin
            in_s0[m]    = (m_araddr[m] >= slave0_addr1) && (m_araddr[m] <= slave0_addr2);
            in_s1[m]    = !in_s0[m] && (m_araddr[m] >= slave1_addr1) && (m_araddr[m] <= slave1_addr2);
            unmapped[m] = !in_s0[m] && !in_s1[m];
            busy[m]     = (dec_state[m] != D_IDLE);
        end
        for (int s = 0; s < 2; s++) begin
            if (slv_state[s] != S_IDLE) begin
                busy[owner[s]] = 1'b1;
            end
        end
        for (int m = 0; m < 2; m++) begin
            req[0][m] = m_arvalid[m] && in_s0[m] && !busy[m];
            req[1][m] = m_arvalid[m] && in_s1[m] && !busy[m];
        end
    end

    // State registers for slave FSMs, ownership, arbitration and DECERR FSMs
    always_ff @(posedge G_clk) begin
        if (!G_reset) begin
            slv_state  <= {S_IDLE, S_IDLE};
            owner      <= '0;
            dec_state  <= {D_IDLE, D_IDLE};
`ifdef AXI_IC_RR_ARB_EN
            last_grant <= 2'b11;
`endif
        end else begin
            slv_state  <= slv_state_nxt;
            owner      <= owner_nxt;
            dec_state  <= dec_state_nxt;
`ifdef AXI_IC_RR_ARB_EN
            last_grant <= last_grant_nxt;
`endif
        end
    end

    // Next-state logic: grant in IDLE, AR handshake, final R beat, DECERR flow
    always_comb begin
        slv_state_nxt  = slv_state;
        owner_nxt      = owner;
        dec_state_nxt  = dec_state;
`ifdef AXI_IC_RR_ARB_EN
        last_grant_nxt = last_grant;
`endif
        for (int s = 0; s < 2; s++) begin
            case (slv_state[s])
                S_IDLE: begin
                    if (req[s] != 2'b00) begin
                        slv_state_nxt[s] = S_ADDR;
                        if (req[s] == 2'b11) begin
`ifdef AXI_IC_RR_ARB_EN
                            owner_nxt[s] = ~last_grant[s];
`else
                            owner_nxt[s] = 1'b0;
`endif
                        end else begin
                            owner_nxt[s] = req[s][1];
                        end
`ifdef AXI_IC_RR_ARB_EN
                        last_grant_nxt[s] = owner_nxt[s];
`endif
                    end
                end
                S_ADDR: begin
                    if (m_arvalid[owner[s]] && s_arready[s]) begin
                        slv_state_nxt[s] = S_DATA;
                    end
                end
                S_DATA: begin
                    if (s_rvalid[s] && m_rready[owner[s]] && s_rlast[s]) begin
                        slv_state_nxt[s] = S_IDLE;
                    end
                end
                default: slv_state_nxt[s] = S_IDLE;
            endcase
        end
        for (int m = 0; m < 2; m++) begin
            case (dec_state[m])
                D_IDLE: begin
                    if (m_arvalid[m] && unmapped[m] && !busy[m]) begin
                        dec_state_nxt[m] = D_ACK;
                    end
                end
                D_ACK:   dec_state_nxt[m] = D_RESP;
                D_RESP: begin
                    if (m_rready[m]) begin
                        dec_state_nxt[m] = D_IDLE;
                    end
                end
                default: dec_state_nxt[m] = D_IDLE;
            endcase
        end
    end

    // Output routing: AR path in ADDR, R path in DATA, DECERR beat generation
    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        m_rlast   = '0;
        m_rresp   = '0;
        m_rdata   = '0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arburst = '0;
        s_arvalid = '0;
        s_rready  = '0;
        for (int s = 0; s < 2; s++) begin
            if (slv_state[s] == S_ADDR) begin
                s_araddr[s]         = m_araddr[owner[s]];
                s_arlen[s]          = m_arlen[owner[s]];
                s_arsize[s]         = m_arsize[owner[s]];
                s_arburst[s]        = m_arburst[owner[s]];
                s_arvalid[s]        = m_arvalid[owner[s]];
                m_arready[owner[s]] = s_arready[s];
            end else if (slv_state[s] == S_DATA) begin
                m_rvalid[owner[s]]  = s_rvalid[s];
                m_rlast[owner[s]]   = s_rlast[s];
                m_rresp[owner[s]]   = s_rresp[s];
                m_rdata[owner[s]]   = s_rdata[s];
                s_rready[s]         = m_rready[owner[s]];
            end
        end
        for (int m = 0; m < 2; m++) begin
            if (dec_state[m] == D_ACK) begin
                m_arready[m] = 1'b1;
            end else if (dec_state[m] == D_RESP) begin
                m_rvalid[m] = 1'b1;
                m_rlast[m]  = 1'b1;
                m_rresp[m]  = RESP_DECERR;
            end
        end
    end

    assign ARREADY_M0 = m_arready[0];
    assign RVALID_M0  = m_rvalid[0];
    assign RLAST_M0   = m_rlast[0];
    assign RRESP_M0   = m_rresp[0];
    assign RDATA_M0   = m_rdata[0];
    assign ARREADY_M1 = m_arready[1];
    assign RVALID_M1  = m_rvalid[1];
    assign RLAST_M1   = m_rlast[1];
    assign RRESP_M1   = m_rresp[1];
    assign RDATA_M1   = m_rdata[1];
    assign ARADDR_S0  = s_araddr[0];
    assign ARLEN_S0   = s_arlen[0];
    assign ARSIZE_S0  = s_arsize[0];
    assign ARBURST_S0 = s_arburst[0];
    assign ARVALID_S0 = s_arvalid[0];
    assign RREADY_S0  = s_rready[0];
    assign ARADDR_S1  = s_araddr[1];
    assign ARLEN_S1   = s_arlen[1];
    assign ARSIZE_S1  = s_arsize[1];
    assign ARBURST_S1 = s_arburst[1];
    assign ARVALID_S1 = s_arvalid[1];
    assign RREADY_S1  = s_rready[1];

endmodule
`default_nettype wire

// File: tb/tb_axi_interconnect.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_interconnect
// Description : Self-checking bench for axi_interconnect. The bench plays both
//               masters and both slaves; expected routing comes from a
//               transaction-level address-map/arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_interconnect;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0][31:0] m_araddr;
    logic [1:0][3:0]  m_arlen;
    logic [1:0][2:0]  m_arsize;
    logic [1:0][1:0]  m_arburst;
    logic [1:0]       m_arvalid;
    logic [1:0]       m_rready;
    logic [1:0]       arready_m;
    logic [1:0]       rvalid_m;
    logic [1:0]       rlast_m;
    logic [1:0][1:0]  rresp_m;
    logic [1:0][31:0] rdata_m;

    logic [1:0]       s_arready;
    logic [1:0]       s_rvalid;
    logic [1:0]       s_rlast;
    logic [1:0][1:0]  s_rresp;
    logic [1:0][31:0] s_rdata;
    logic [1:0][31:0] araddr_s;
    logic [1:0][3:0]  arlen_s;
    logic [1:0][2:0]  arsize_s;
    logic [1:0][1:0]  arburst_s;
    logic [1:0]       arvalid_s;
    logic [1:0]       rready_s;

    logic [31:0] lo0 = 32'd1;
    logic [31:0] hi0 = 32'd5;
    logic [31:0] lo1 = 32'd10;
    logic [31:0] hi1 = 32'd15;

    logic [159:0] all_out;
    assign all_out = {arready_m, rvalid_m, rlast_m, rresp_m, rdata_m,
                      araddr_s, arlen_s, arsize_s, arburst_s, arvalid_s, rready_s};

    int checks = 0;
    int errors = 0;

    // model state: last master granted per slave (reset points at M1)
    int last_win [2] = '{1, 1};

    axi_interconnect dut (
        .G_clk(clk), .G_reset(rst_n),
        .M0_ARADDR(m_araddr[0]), .M0_ARLEN(m_arlen[0]), .M0_ARSIZE(m_arsize[0]),
        .M0_ARBURST(m_arburst[0]), .M0_ARVALID(m_arvalid[0]), .M0_RREADY(m_rready[0]),
        .ARREADY_M0(arready_m[0]), .RVALID_M0(rvalid_m[0]), .RLAST_M0(rlast_m[0]),
        .RRESP_M0(rresp_m[0]), .RDATA_M0(rdata_m[0]),
        .M1_ARADDR(m_araddr[1]), .M1_ARLEN(m_arlen[1]), .M1_ARSIZE(m_arsize[1]),
        .M1_ARBURST(m_arburst[1]), .M1_ARVALID(m_arvalid[1]), .M1_RREADY(m_rready[1]),
        .ARREADY_M1(arready_m[1]), .RVALID_M1(rvalid_m[1]), .RLAST_M1(rlast_m[1]),
        .RRESP_M1(rresp_m[1]), .RDATA_M1(rdata_m[1]),
        .S0_ARREADY(s_arready[0]), .S0_RVALID(s_rvalid[0]), .S0_RLAST(s_rlast[0]),
        .S0_RRESP(s_rresp[0]), .S0_RDATA(s_rdata[0]),
        .ARADDR_S0(araddr_s[0]), .ARLEN_S0(arlen_s[0]), .ARSIZE_S0(arsize_s[0]),
        .ARBURST_S0(arburst_s[0]), .ARVALID_S0(arvalid_s[0]), .RREADY_S0(rready_s[0]),
        .S1_ARREADY(s_arready[1]), .S1_RVALID(s_rvalid[1]), .S1_RLAST(s_rlast[1]),
        .S1_RRESP(s_rresp[1]), .S1_RDATA(s_rdata[1]),
        .ARADDR_S1(araddr_s[1]), .ARLEN_S1(arlen_s[1]), .ARSIZE_S1(arsize_s[1]),
        .ARBURST_S1(arburst_s[1]), .ARVALID_S1(arvalid_s[1]), .RREADY_S1(rready_s[1]),
        .slave0_addr1(lo0), .slave0_addr2(hi0),
        .slave1_addr1(lo1), .slave1_addr2(hi1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one cycle: land just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference address map: 0/1 = slave index, 2 = unmapped
    function automatic int route(input logic [31:0] a);
        if (a >= lo0 && a <= hi0) return 0;
        if (a >= lo1 && a <= hi1) return 1;
        return 2;
    endfunction

    // contention winner per arbitration rule
    function automatic int contend_winner(input int s);
`ifdef AXI_IC_RR_ARB_EN
        return 1 - last_win[s];
`else
        return (s >= 0) ? 0 : 1;
`endif
    endfunction

    task automatic clear_inputs();
        m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
        m_arvalid = '0; m_rready = '0;
        s_arready = '0; s_rvalid = '0; s_rlast = '0; s_rresp = '0; s_rdata = '0;
    endtask

    // master m owns slave s in ADDR: finish AR handshake and one R beat
    task automatic complete(input int m, input int s);
        logic [31:0] d;
        d = $urandom;
        s_arready[s] = 1'b1;
        #1;
        chk("cmp_arready", arready_m[m], 1);
        chk("cmp_arready_other", arready_m[1-m], 0);
        tick();
        m_arvalid[m] = 1'b0;
        s_arready[s] = 1'b0;
        s_rvalid[s] = 1'b1; s_rlast[s] = 1'b1; s_rdata[s] = d; s_rresp[s] = 2'b00;
        #1;
        chk("cmp_rdata", rdata_m[m], d);
        chk("cmp_rvalid_other", rvalid_m[1-m], 0);
        m_rready[m] = 1'b1;
        tick();
        s_rvalid[s] = 1'b0; s_rlast[s] = 1'b0; s_rdata[s] = '0;
        m_rready[m] = 1'b0;
        last_win[s] = m;
    endtask

    // full single-master read; route and payload checked against the model
    task automatic read_txn(input int m, input logic [31:0] a, input logic [3:0] len,
                            input logic [2:0] sz, input logic [1:0] bu,
                            input logic [31:0] d, input logic [1:0] rr,
                            input int ardly, input int rdly);
        int s;
        s = route(a);
        m_araddr[m] = a; m_arlen[m] = len; m_arsize[m] = sz; m_arburst[m] = bu;
        m_arvalid[m] = 1'b1;
        #1;
        chk("arready_pre_grant", arready_m[m], 0);
        chk("arvalid_pre_grant", arvalid_s, 0);
        tick();
        if (s < 2) begin
            last_win[s] = m;
            for (int k = 0; k < ardly; k++) begin
                chk("arvalid_held", arvalid_s[s], 1);
                chk("arready_wait", arready_m[m], 0);
                tick();
            end
            chk("araddr_fwd", araddr_s[s], a);
            chk("arlen_fwd", arlen_s[s], len);
            chk("arsize_fwd", arsize_s[s], sz);
            chk("arburst_fwd", arburst_s[s], bu);
            chk("arvalid_fwd", arvalid_s[s], 1);
            chk("unsel_arvalid", arvalid_s[1-s], 0);
            chk("unsel_araddr", araddr_s[1-s], 0);
            s_arready[s] = 1'b1;
            #1;
            chk("arready_pass", arready_m[m], 1);
            tick();
            m_arvalid[m] = 1'b0;
            s_arready[s] = 1'b0;
            #1;
            chk("arvalid_after_hs", arvalid_s[s], 0);
            chk("arready_busy", arready_m[m], 0);
            for (int k = 0; k < rdly; k++) begin
                chk("rvalid_idle_beat", rvalid_m[m], 0);
                tick();
            end
            s_rvalid[s] = 1'b1; s_rlast[s] = 1'b1; s_rdata[s] = d; s_rresp[s] = rr;
            #1;
            chk("rvalid_route", rvalid_m[m], 1);
            chk("rlast_route", rlast_m[m], 1);
            chk("rresp_route", rresp_m[m], rr);
            chk("rdata_route", rdata_m[m], d);
            chk("rvalid_nonowner", rvalid_m[1-m], 0);
            chk("rdata_nonowner", rdata_m[1-m], 0);
            chk("rready_before", rready_s[s], 0);
            m_rready[m] = 1'b1;
            #1;
            chk("rready_pass", rready_s[s], 1);
            tick();
            s_rvalid[s] = 1'b0; s_rlast[s] = 1'b0; s_rdata[s] = '0; s_rresp[s] = '0;
            m_rready[m] = 1'b0;
            #1;
            chk("rready_idle", rready_s[s], 0);
            chk("rvalid_done", rvalid_m[m], 0);
        end else begin
            chk("decerr_arready", arready_m[m], 1);
            chk("decerr_no_fwd", arvalid_s, 0);
            tick();
            m_arvalid[m] = 1'b0;
            #1;
            chk("decerr_arready_pulse", arready_m[m], 0);
            for (int k = 0; k <= rdly; k++) begin
                chk("decerr_rvalid", rvalid_m[m], 1);
                chk("decerr_rlast", rlast_m[m], 1);
                chk("decerr_rresp", rresp_m[m], 2'b11);
                chk("decerr_rdata", rdata_m[m], 0);
                chk("decerr_other", rvalid_m[1-m], 0);
                if (k < rdly) tick();
            end
            m_rready[m] = 1'b1;
            tick();
            m_rready[m] = 1'b0;
            #1;
            chk("decerr_done", rvalid_m[m], 0);
        end
    endtask

    logic [31:0] bnd [8] = '{32'd0, 32'd1, 32'd5, 32'd6, 32'd9, 32'd10, 32'd15, 32'd16};

    initial begin
        int w;
        int l;
        logic [31:0] a;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_outputs", |all_out, 0);
        m_arvalid = 2'b11; m_araddr[0] = 32'd2; m_araddr[1] = 32'd12;
        #1;
        chk("reset_ignores_arvalid", |all_out, 0);
        tick();
        chk("reset_held_outputs", |all_out, 0);
        m_arvalid = 2'b00;
        rst_n = 1'b1;
        tick();
        chk("post_reset_outputs", |all_out, 0);

        // basic S0 read and S1 read
        read_txn(0, 32'd2, 4'd1, 3'd1, 2'd1, 32'd1, 2'd1, 0, 0);
        read_txn(1, 32'd11, 4'd15, 3'd7, 2'd3, 32'd2, 2'd1, 0, 0);
        // unmapped address
        read_txn(0, 32'd7, 4'd0, 3'd0, 2'd0, 32'd0, 2'd0, 0, 2);

        // concurrent use of both slaves
        m_araddr[0] = 32'd2;  m_arlen[0] = 4'd3; m_arvalid[0] = 1'b1;
        m_araddr[1] = 32'd12; m_arlen[1] = 4'd4; m_arvalid[1] = 1'b1;
        tick();
        chk("conc_arvalid", arvalid_s, 2'b11);
        chk("conc_araddr0", araddr_s[0], 2);
        chk("conc_araddr1", araddr_s[1], 12);
        s_arready = 2'b11;
        #1;
        chk("conc_arready", arready_m, 2'b11);
        tick();
        m_arvalid = 2'b00; s_arready = 2'b00;
        s_rvalid = 2'b11; s_rlast = 2'b11;
        s_rdata[0] = 32'hA0A0; s_rdata[1] = 32'hB1B1;
        #1;
        chk("conc_rdata0", rdata_m[0], 32'hA0A0);
        chk("conc_rdata1", rdata_m[1], 32'hB1B1);
        m_rready = 2'b11;
        tick();
        s_rvalid = 2'b00; s_rlast = 2'b00; s_rdata = '0; m_rready = 2'b00;
        last_win[0] = 0; last_win[1] = 1;

        // same-slave contention: reset arbitration state first
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        last_win[0] = 1; last_win[1] = 1;
        tick();
        m_araddr[0] = 32'd3; m_arlen[0] = 4'd1; m_arvalid[0] = 1'b1;
        m_araddr[1] = 32'd3; m_arlen[1] = 4'd2; m_arvalid[1] = 1'b1;
        w = contend_winner(0);
        tick();
        chk("cont1_winner_len", arlen_s[0], (w == 0) ? 1 : 2);
        chk("cont1_loser_arready", arready_m[1-w], 0);
        complete(w, 0);
        // winner reissues while the loser is still waiting: second contention
        m_arvalid[w] = 1'b1;
        m_arlen[w] = (w == 0) ? 4'd1 : 4'd2;
        tick();
        l = w;
        w = contend_winner(0);
        chk("cont2_winner_len", arlen_s[0], (w == 0) ? 1 : 2);
        complete(w, 0);
        tick();
        chk("cont2_loser_granted", arlen_s[0], (w == 0) ? 2 : 1);
        complete(1 - w, 0);
        l = l + 0;

        // reset in the middle of an S0 data phase
        m_araddr[0] = 32'd4; m_arvalid[0] = 1'b1;
        tick();
        s_arready[0] = 1'b1;
        tick();
        m_arvalid[0] = 1'b0; s_arready[0] = 1'b0;
        s_rvalid[0] = 1'b1; s_rlast[0] = 1'b1; s_rdata[0] = 32'd77;
        #1;
        chk("mid_rvalid", rvalid_m[0], 1);
        rst_n = 1'b0;
        tick();
        chk("mid_reset_outputs", |all_out, 0);
        rst_n = 1'b1;
        tick();
        chk("after_reset_no_beat", rvalid_m[0], 0);
        s_rvalid[0] = 1'b0; s_rlast[0] = 1'b0; s_rdata[0] = '0;
        last_win[0] = 1; last_win[1] = 1;
        read_txn(0, 32'd4, 4'd2, 3'd2, 2'd1, 32'hCAFE, 2'd0, 1, 1);

        // randomized reads: boundary addresses first, then random
        for (int i = 0; i < 24; i++) begin
            if (i < 8) a = bnd[i];
            else if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = $urandom_range(0, 20);
            read_txn($urandom_range(0, 1), a, 4'($urandom), 3'($urandom), 2'($urandom),
                     $urandom, 2'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_interconnect.md
AXI_INTERCONNECT -- requirements
Module: axi_interconnect

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: G_clk (clock), G_reset (reset, active-low, synchronous).
REQ-002 Ports: G_clk  in  1  clock, rising edge.
REQ-003 Ports: G_reset  in  1  synchronous active-low reset.
REQ-004 Per master m in {0,1}, inputs: Mm_ARADDR 32, Mm_ARLEN 4, Mm_ARSIZE 3, Mm_ARBURST 2, Mm_ARVALID 1, Mm_RREADY 1; outputs: ARREADY_Mm 1, RVALID_Mm 1, RLAST_Mm 1, RRESP_Mm 2, RDATA_Mm 32.
REQ-005 Per slave s in {0,1}, inputs: Ss_ARREADY 1, Ss_RVALID 1, Ss_RLAST 1, Ss_RRESP 2, Ss_RDATA 32; outputs: ARADDR_Ss 32, ARLEN_Ss 4, ARSIZE_Ss 3, ARBURST_Ss 2, ARVALID_Ss 1, RREADY_Ss 1.
REQ-006 Address map inputs, 32 bits each: slave0_addr1, slave0_addr2, slave1_addr1, slave1_addr2; inclusive low/high bounds per slave.

Function
REQ-007 SHALL implement the AXI read path only (AR and R channels), 2 masters x 2 slaves.
REQ-008 Decode: ARADDR in [slaveS_addr1, slaveS_addr2] inclusive, unsigned, selects slave S; slave 0 wins if ranges overlap.
REQ-009 Unmapped address: ARREADY_Mm asserts for one cycle, then a single-beat response RVALID=1, RLAST=1, RRESP=2'b11 (DECERR), RDATA=0, held until Mm_RREADY.
REQ-010 Each slave has an FSM: IDLE -> ADDR (grant registered on the edge where a decoded ARVALID is present) -> DATA (on ARVALID_Ss && Ss_ARREADY) -> IDLE (on Ss_RVALID && RREADY_Ss && Ss_RLAST).
REQ-011 ADDR: AR payload and ARVALID of the granted master pass combinationally to slave; Ss_ARREADY passes combinationally to ARREADY_Mm; ARVALID_Ss is asserted exactly one cycle after master ARVALID is sampled in IDLE.
REQ-012 DATA: Ss_RVALID/RLAST/RRESP/RDATA route combinationally to the owning master; Mm_RREADY routes to RREADY_Ss; non-owning master sees RVALID=0, RDATA=0, RRESP=0, RLAST=0.
REQ-013 Both slaves operate concurrently when masters target different slaves.
REQ-014 Each master has at most one outstanding read; ARREADY_Mm SHALL be 0 while that master owns any slave or a pending DECERR.
REQ-015 A grant is held until the AR handshake completes; it is never revoked while ARVALID is pending.
REQ-016 Contention for the same slave in the same cycle: arbitration per Configuration; loser waits in its own ARVALID.
REQ-017 Unselected slave AR outputs SHALL be 0; RREADY_Ss=0 outside DATA.

Reset
REQ-018 While G_reset=0 at a rising edge: all FSMs to IDLE, ownership/priority state cleared, last-grant pointer to M1 (so M0 wins first).
REQ-019 During and after reset until a grant: every output SHALL be 0.
REQ-020 Reset mid-transaction aborts it; no further beats are forwarded.

Configuration
REQ-021 Macro AXI_IC_RR_ARB_EN: when defined, same-slave contention uses round-robin (master not granted last wins); when undefined, fixed priority, M0 always wins.

Verification
REQ-022 Ranges 1..5 / 10..15; M0 ARADDR=2, LEN=1, SIZE=1, BURST=1 -> ARVALID_S0=1 next cycle with identical payload; S0_ARREADY=1 -> ARREADY_M0=1, handshake.
REQ-023 After REQ-022, S0 RVALID=1, RLAST=1, RRESP=1, RDATA=1 -> M0 sees same values; M0_RREADY=1 -> RREADY_S0=1, S0 FSM to IDLE.
REQ-024 M1 ARADDR=11, LEN=15, SIZE=7, BURST=3 -> forwarded to S1; S1 returns RDATA=2, RRESP=1, RLAST=1 -> delivered to M1 only; M0 outputs stay 0.
REQ-025 M0 and M1 both ARADDR=3 same cycle -> M0 granted first; with AXI_IC_RR_ARB_EN the next contention grants M1.
REQ-026 M0 ARADDR=7 (unmapped) -> ARREADY_M0 pulse, then RVALID_M0=1, RLAST=1, RRESP=2'b11 until RREADY.
REQ-027 G_reset=0 during S0 DATA phase -> all outputs 0 next edge; new read afterwards completes normally.
